// File: rtl/fetch_unit.sv
// fetch_unit: two-state instruction fetch front end (FETCH / EXEC).
// Requests one instruction word at pc, holds it in instr until the datapath
// retires it, then computes the next pc from jr / jump / branch controls.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- when defined, a misaligned
// next-pc halts the unit in a HALT state and raises a sticky misalign flag;
// when undefined, next-pc bits [1:0] are simply forced to zero.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] signimm,
    input  logic [25:0] jtarget,
    input  logic [31:0] rsdata,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [31:0] pcplus4
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] S_HALT  = 2'd2;
`endif

    logic [1:0]  state;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;
    logic        retire;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    // Retirement only counts while an instruction is actually held in EXEC.
    assign retire = (state == S_EXEC) && advance;

    // Sequential and control-flow target arithmetic, all modulo 2^32.
    always_comb begin
        pcplus4       = pc + 32'd4;
        branch_target = pcplus4 + (signimm << 2);
        jump_target   = {pcplus4[31:28], jtarget, 2'b00};
    end

    // Next-pc selection: jr beats jump beats taken branch beats fall-through.
    always_comb begin
        next_pc_raw = pcplus4;
        if (jr) begin
            next_pc_raw = rsdata;
        end else if (jump) begin
            next_pc_raw = jump_target;
        end else if (pcsrc) begin
            next_pc_raw = branch_target;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // The offending address is kept intact so software can see where it went.
    always_comb begin
        misaligned = (next_pc_raw[1:0] != 2'b00);
        next_pc    = next_pc_raw;
    end
`else
    // Without the trap, the low address bits are silently dropped.
    always_comb begin
        next_pc = next_pc_raw & 32'hFFFF_FFFC;
    end
`endif

    // Control state: wait for the memory ack in FETCH, wait for retirement in EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (advance) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        state <= misaligned ? S_HALT : S_FETCH;
`else
                        state <= S_FETCH;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                S_HALT: begin
                    state <= S_HALT;
                end
`endif
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Program counter moves only when the held instruction retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (retire) begin
            pc <= next_pc;
        end
    end

    // Instruction register captures the memory word on the accepting ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr <= 32'h0000_0000;
        end else if ((state == S_FETCH) && imem_ack) begin
            instr <= imem_rdata;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky misalignment flag; only a reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign <= 1'b0;
        end else if (retire && misaligned) begin
            misalign <= 1'b1;
        end
    end
`endif

    // The request is gated by reset so it drops the moment reset asserts and
    // rises in the first cycle after release, when state is already FETCH.
    always_comb begin
        imem_req    = reset && (state == S_FETCH);
        imem_addr   = pc;
        instr_valid = (state == S_EXEC);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Expected fetch addresses and
// instruction words are queued as stimulus is driven; a negedge monitor pops
// them when instr_valid rises. Scenario tasks add their own inline checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcsrc;
    logic        jump;
    logic        jr;
    logic [31:0] signimm;
    logic [25:0] jtarget;
    logic [31:0] rsdata;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] model_pc;
    logic        prev_valid = 1'b0;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .pcsrc      (pcsrc),
        .jump       (jump),
        .jr         (jr),
        .signimm    (signimm),
        .jtarget    (jtarget),
        .rsdata     (rsdata),
        .advance    (advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign   (misalign),
`endif
        .pcplus4    (pcplus4)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: each completed fetch must match the next queued entry.
    always @(negedge clk) begin
        if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
            checks++;
            if (exp_pc_q.size() == 0 || exp_instr_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb_unexpected_fetch got pc=%h instr=%h required=no fetch", pc, instr);
            end else begin
                logic [31:0] e_pc;
                logic [31:0] e_in;
                e_pc = exp_pc_q.pop_front();
                e_in = exp_instr_q.pop_front();
                if (pc !== e_pc) begin
                    failures++;
                    $display("[TB] FAIL sb_pc got=%h required=%h", pc, e_pc);
                end
                checks++;
                if (instr !== e_in) begin
                    failures++;
                    $display("[TB] FAIL sb_instr got=%h required=%h", instr, e_in);
                end
            end
        end
        prev_valid = instr_valid;
    end

    // Hard stop in case the bench ever wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic p, input logic j,
                                               input logic r, input logic [31:0] si,
                                               input logic [25:0] jt, input logic [31:0] rs);
        logic [31:0] p4;
        p4 = cur + 32'd4;
        if (r)      return rs;
        else if (j) return {p4[31:28], jt, 2'b00};
        else if (p) return p4 + (si << 2);
        else        return p4;
    endfunction

    // Retire the held instruction with the given controls and queue the next fetch.
    task automatic step_exec(input logic p, input logic j, input logic r, input logic [31:0] si,
                             input logic [25:0] jt, input logic [31:0] rs, output logic [31:0] exp_addr);
        logic [31:0] raw;
        raw = model_next(model_pc, p, j, r, si, jt, rs);
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_addr = raw;
        if (raw[1:0] == 2'b00) exp_pc_q.push_back(raw);
`else
        exp_addr = raw & 32'hFFFF_FFFC;
        exp_pc_q.push_back(exp_addr);
`endif
        model_pc = exp_addr;
        pcsrc = p; jump = j; jr = r; signimm = si; jtarget = jt; rsdata = rs;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        pcsrc = 1'($urandom()); jump = 1'($urandom()); jr = 1'($urandom());
        signimm = $urandom(); jtarget = 26'($urandom()); rsdata = $urandom();
    endtask

    // Answer the pending request after 'delay' idle request cycles.
    task automatic serve_fetch(input int delay, input logic [31:0] data);
        exp_instr_q.push_back(data);
        repeat (delay) tick();
        imem_ack = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack = 1'b0;
        imem_rdata = $urandom();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b required=0", imem_req); end
        checks++; if (pc !== RST_PC) begin failures++; $display("[TB] FAIL reset_pc got=%h required=%h", pc, RST_PC); end
        checks++; if (instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got=%h required=0", instr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b required=0", instr_valid); end
        imem_ack = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL release_req got=%b required=1", imem_req); end
        checks++; if (imem_addr !== RST_PC) begin failures++; $display("[TB] FAIL release_addr got=%h required=%h", imem_addr, RST_PC); end
        model_pc = RST_PC;
        exp_pc_q.push_back(RST_PC);
    endtask

    task automatic test_fast_fetch();
        serve_fetch(0, 32'h2008_0005);
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL fast_valid got=%b required=1", instr_valid); end
        checks++; if (instr !== 32'h2008_0005) begin failures++; $display("[TB] FAIL fast_instr got=%h required=20080005", instr); end
        checks++; if (pc !== 32'h0) begin failures++; $display("[TB] FAIL fast_pc got=%h required=0", pc); end
        checks++; if (pcplus4 !== 32'h4) begin failures++; $display("[TB] FAIL fast_pcplus4 got=%h required=4", pcplus4); end
    endtask

    task automatic test_exec_hold();
        for (int i = 0; i < 4; i++) begin
            pcsrc = 1'($urandom()); jump = 1'($urandom()); jr = 1'($urandom());
            rsdata = $urandom(); signimm = $urandom();
            imem_ack = 1'b1;
            imem_rdata = 32'hA5A5_0000 + i;
            tick();
            checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL hold_req got=%b required=0", imem_req); end
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL hold_valid got=%b required=1", instr_valid); end
            checks++; if (instr !== 32'h2008_0005) begin failures++; $display("[TB] FAIL hold_instr got=%h required=20080005", instr); end
            checks++; if (pc !== model_pc) begin failures++; $display("[TB] FAIL hold_pc got=%h required=%h", pc, model_pc); end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_slow_fetch();
        logic [31:0] ea;
        step_exec(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, ea);
        exp_instr_q.push_back(32'h8C01_0004);
        advance = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL slow_req cycle=%0d got=%b required=1", i, imem_req); end
            checks++; if (imem_addr !== 32'h4) begin failures++; $display("[TB] FAIL slow_addr cycle=%0d got=%h required=4", i, imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL slow_valid cycle=%0d got=%b required=0", i, instr_valid); end
            if (i == 3) begin
                imem_ack = 1'b1;
                imem_rdata = 32'h8C01_0004;
            end
            tick();
        end
        advance = 1'b0;
        imem_ack = 1'b0;
        checks++; if (pc !== 32'h4) begin failures++; $display("[TB] FAIL slow_pc got=%h required=4", pc); end
    endtask

    task automatic test_branch_jump();
        logic [31:0] ea;
        step_exec(1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h40, ea);
        serve_fetch(1, 32'h1000_0001);
        step_exec(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, ea);
        checks++; if (imem_addr !== 32'h3C) begin failures++; $display("[TB] FAIL branch_back got=%h required=3c", imem_addr); end
        serve_fetch(0, 32'h1000_0002);
        step_exec(1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h40, ea);
        serve_fetch(2, 32'h1000_0003);
        step_exec(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h123456, 32'h0, ea);
        checks++; if (imem_addr !== 32'h0048_D158) begin failures++; $display("[TB] FAIL jump_over_branch got=%h required=0048d158", imem_addr); end
        serve_fetch(0, 32'h1000_0004);
    endtask

    task automatic test_priority();
        logic [31:0] ea;
        step_exec(1'b1, 1'b1, 1'b1, 32'h0000_0010, 26'h3FF_FFFF, 32'h100, ea);
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL jr_priority got=%h required=100", imem_addr); end
        serve_fetch(1, 32'h2000_0005);
    endtask

    task automatic test_wrap();
        logic [31:0] ea;
        step_exec(1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'hFFFF_FFFC, ea);
        serve_fetch(0, 32'h3000_0006);
        checks++; if (pcplus4 !== 32'h0) begin failures++; $display("[TB] FAIL wrap_pcplus4 got=%h required=0", pcplus4); end
        step_exec(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, ea);
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL wrap_addr got=%h required=0", imem_addr); end
        serve_fetch(0, 32'h3000_0007);
    endtask

    task automatic test_misalign();
        logic [31:0] ea;
        step_exec(1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h102, ea);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            checks++; if (misalign !== 1'b1) begin failures++; $display("[TB] FAIL halt_flag got=%b required=1", misalign); end
            checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL halt_req got=%b required=0", imem_req); end
            checks++; if (pc !== 32'h102) begin failures++; $display("[TB] FAIL halt_pc got=%h required=102", pc); end
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL halt_valid got=%b required=0", instr_valid); end
            imem_ack = 1'b1;
            advance = 1'b1;
            tick();
        end
        imem_ack = 1'b0;
        advance = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL halt_clear got=%b required=0", misalign); end
        tick();
        reset = 1'b1;
        model_pc = RST_PC;
        exp_pc_q.push_back(RST_PC);
        #1;
        serve_fetch(0, 32'h4000_0008);
`else
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL align_addr got=%h required=100", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL align_req got=%b required=1", imem_req); end
        serve_fetch(1, 32'h4000_0008);
`endif
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] ea;
        step_exec(1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h0000_0200, ea);
        tick();
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL midreset_req got=%b required=0", imem_req); end
        checks++; if (pc !== RST_PC) begin failures++; $display("[TB] FAIL midreset_pc got=%h required=%h", pc, RST_PC); end
        exp_pc_q.delete();
        model_pc = RST_PC;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        tick();
        imem_ack = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL restart_req got=%b required=1", imem_req); end
        checks++; if (imem_addr !== RST_PC) begin failures++; $display("[TB] FAIL restart_addr got=%h required=%h", imem_addr, RST_PC); end
        checks++; if (instr !== 32'h0) begin failures++; $display("[TB] FAIL restart_instr got=%h required=0", instr); end
        exp_pc_q.push_back(RST_PC);
        serve_fetch(2, 32'h5000_0009);
        checks++; if (pc !== RST_PC) begin failures++; $display("[TB] FAIL restart_pc got=%h required=%h", pc, RST_PC); end
    endtask

    initial begin
        reset = 1'b0;
        pcsrc = 1'b0; jump = 1'b0; jr = 1'b0;
        signimm = 32'h0; jtarget = 26'h0; rsdata = 32'h0;
        advance = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        model_pc = RST_PC;
        test_reset();
        test_fast_fetch();
        test_exec_hold();
        test_slow_fetch();
        test_branch_jump();
        test_priority();
        test_wrap();
        test_misalign();
        test_reset_mid_fetch();
        tick();
        checks++;
        if (exp_pc_q.size() != 0 || exp_instr_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL sb_drain got pc_left=%0d instr_left=%0d required=0", exp_pc_q.size(), exp_instr_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
